simd_fu_sequencer: RTL

SIMD_FU_SEQUENCER -- requirements
Module: simd_fu_sequencer

---
 rtl/simd_fu_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/simd_fu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : simd_fu_sequencer
// Brief    : Issues one SIMD instruction at a time to the functional units,
//            timing multiply latency and VREDSUM passes. Optional macro
//            SIMD_SEQ_PERF_EN adds issue/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================

package simd_fu_sequencer_pkg;

    typedef logic [4:0] simd_op_t;

    localparam simd_op_t VNOP    = 5'd0;
    localparam simd_op_t VADD    = 5'd1;
    localparam simd_op_t VSUB    = 5'd2;
    localparam simd_op_t VAND    = 5'd3;
    localparam simd_op_t VOR     = 5'd4;
    localparam simd_op_t VXOR    = 5'd5;
    localparam simd_op_t VSLL    = 5'd6;
    localparam simd_op_t VSRL    = 5'd7;
    localparam simd_op_t VMUL    = 5'd8;
    localparam simd_op_t VMULH   = 5'd9;
    localparam simd_op_t VMULHU  = 5'd10;
    localparam simd_op_t VMULHSU = 5'd11;
    localparam simd_op_t VREDSUM = 5'd12;

    typedef struct packed {
        simd_op_t   instr_type;
        logic [4:0] vd;
        logic [4:0] vs1;
        logic [4:0] vs2;
    } simd_instr_t;

    typedef struct packed {
        simd_instr_t instr;
        logic [1:0]  sew;
    } rr_exe_simd_instr_t;

endpackage

module simd_fu_sequencer
    import simd_fu_sequencer_pkg::*;
#(
    parameter int MUL_LAT    = 2,
    parameter int RED_PASSES = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               instr_valid_i,
    input  rr_exe_simd_instr_t instr_i,
    output logic               instr_ready_o,
    input  logic               flush_i,
    output rr_exe_simd_instr_t fu_instr_o,
    output rr_exe_simd_instr_t fu_sel_out_o,
    output logic               result_valid_o,
    output logic [2:0]         red_pass_o,
    output logic               busy_o
`ifdef SIMD_SEQ_PERF_EN
    ,
    output logic [31:0]        perf_issued_o,
    output logic [31:0]        perf_stall_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RED  = 2'd3
    } state_e;

    localparam logic [2:0] MUL_LAST = 3'(MUL_LAT - 1);
    localparam logic [2:0] RED_LAST = 3'(RED_PASSES - 1);

    state_e             state_q, state_d;
    rr_exe_simd_instr_t iss_q, iss_d;
    logic [2:0]         cnt_q, cnt_d;

    logic   mul_last;
    logic   red_last;
    logic   final_cycle;
    logic   accept;
    state_e issue_state;

    // One counter serves both the multiply latency and the reduction pass index.
    assign mul_last    = (state_q == ST_MUL) && (cnt_q == MUL_LAST);
    assign red_last    = (state_q == ST_RED) && (cnt_q == RED_LAST);
    assign final_cycle = (state_q == ST_EXEC) || mul_last || red_last;

    assign instr_ready_o = !flush_i && ((state_q == ST_IDLE) || final_cycle);
    assign accept        = instr_valid_i && instr_ready_o;

    always_comb begin
        issue_state = ST_EXEC;
        case (instr_i.instr.instr_type)
            VMUL, VMULH, VMULHU, VMULHSU: issue_state = ST_MUL;
            VREDSUM:                      issue_state = ST_RED;
            default:                      issue_state = ST_EXEC;
        endcase
    end

    always_comb begin
        state_d = state_q;
        iss_d   = iss_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else if (accept) begin
            iss_d   = instr_i;
            state_d = issue_state;
            cnt_d   = 3'd0;
        end else if (final_cycle) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
        end else if (state_q != ST_IDLE) begin
            cnt_d   = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            iss_q   <= '0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            iss_q   <= iss_d;
            cnt_q   <= cnt_d;
        end
    end

    // Multiply results are only selected on the cycle the product is ready.
    assign fu_instr_o     = (state_q == ST_IDLE) ? '0 : iss_q;
    assign fu_sel_out_o   = ((state_q == ST_EXEC) || (state_q == ST_RED) || mul_last) ? iss_q : '0;
    assign result_valid_o = !flush_i && final_cycle;
    assign red_pass_o     = (state_q == ST_RED) ? cnt_q : 3'd0;
    assign busy_o         = (state_q != ST_IDLE);

`ifdef SIMD_SEQ_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_issued_d = perf_issued_q + 32'(accept);
        perf_stall_d  = perf_stall_q + 32'(instr_valid_i && !instr_ready_o);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_issued_q <= 32'd0;
            perf_stall_q  <= 32'd0;
        end else begin
            perf_issued_q <= perf_issued_d;
            perf_stall_q  <= perf_stall_d;
        end
    end

    assign perf_issued_o = perf_issued_q;
    assign perf_stall_o  = perf_stall_q;
`endif

endmodule

`default_nettype wire
